eth_tx_pause_responder: RTL and testbench

Receive-side flow-control responder for one Ethernet channel, running in the HSSI TX clock domain. It takes 802.3x PAUSE and 802.1Qbb PFC indications decoded by the MAC and gates the AFU TX AXI-Stream toward the HSSI subsystem, stopping only at packet boundaries. It is the counterpart of the HE-HSSI pause/PFC request path: that path asks the link partner to stop, and this block honours the link partner's requests to stop us. It is instantiated once per channel, between the traffic controller TX stream and the HSSI SS TX interface.

---
 rtl/eth_tx_pause_responder_if.sv | 17 +
 rtl/eth_tx_pause_responder.sv | 136 +++++++++++++
 tb/tb_eth_tx_pause_responder.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_tx_pause_responder_if.sv
// AXI-Stream bundle for the TX path of one Ethernet channel.
//   master : drives tvalid/tdata/tkeep/tlast/tuser, receives tready
//   slave  : receives tvalid/tdata/tkeep/tlast/tuser, drives tready
interface eth_tx_pause_responder_if #(
    parameter int DW = 64,
    parameter int UW = 1
) ();
    logic            tvalid;
    logic            tready;
    logic [DW-1:0]   tdata;
    logic [DW/8-1:0] tkeep;
    logic            tlast;
    logic [UW-1:0]   tuser;

    modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/eth_tx_pause_responder.sv
// Honours link-partner 802.3x PAUSE and 802.1Qbb PFC requests by gating the
// AFU TX AXI-Stream toward the HSSI subsystem, only ever at packet boundaries.
// Ports:
//   clk, softreset        HSSI TX clock, synchronous active-high reset
//   i_fc_enable           1 = honour PAUSE/PFC, 0 = pass everything (timers still run)
//   i_rx_pause_*          PAUSE strobe and quanta from the MAC
//   i_rx_pfc_*            PFC strobe, per-class enable and quanta from the MAC
//   i_tx_class            priority class of the packet at the SOP beat
//   s / m                 upstream (slave) and downstream (master) AXI-Stream
//   o_pause_active        global PAUSE timer nonzero
//   o_pfc_active          per-class PFC timer nonzero
//   o_xoff_events         saturating count of cycles carrying a nonzero-quanta event
module eth_tx_pause_responder #(
    parameter int DW            = 64,
    parameter int UW            = 1,
    parameter int QUANTA_CYCLES = 8
) (
    input  logic        clk,
    input  logic        softreset,
    input  logic        i_fc_enable,
    input  logic        i_rx_pause_valid,
    input  logic [15:0] i_rx_pause_quanta,
    input  logic        i_rx_pfc_valid,
    input  logic [7:0]  i_rx_pfc_class_en,
    input  logic [15:0] i_rx_pfc_quanta,
    input  logic [2:0]  i_tx_class,
    eth_tx_pause_responder_if.slave  s,
    eth_tx_pause_responder_if.master m,
    output logic        o_pause_active,
    output logic [7:0]  o_pfc_active,
    output logic [15:0] o_xoff_events
);

    localparam int PW = (QUANTA_CYCLES > 1) ? $clog2(QUANTA_CYCLES) : 1;
    localparam logic [PW-1:0] P_RELOAD = PW'(QUANTA_CYCLES - 1);
    localparam int NT = 9;  // timers 0..7 = PFC classes, 8 = global PAUSE

    typedef enum logic {IDLE, PKT} state_t;

    state_t        state_q;
    logic [15:0]   tq_q [NT];
    logic [15:0]   tq_d [NT];
    logic [PW-1:0] tp_q [NT];
    logic [PW-1:0] tp_d [NT];
    logic [15:0]   xoff_q, xoff_d;
    logic [NT-1:0] ld;
    logic          event_w;
    logic          blocked;
    logic          hs;

    // Timer next-state: a strobe overwrites (XON loads zero), otherwise count down.
    always_comb begin
        ld = {i_rx_pause_valid, {8{i_rx_pfc_valid}} & i_rx_pfc_class_en};
        for (int unsigned t = 0; t < NT; t++) begin
            tq_d[t] = tq_q[t];
            tp_d[t] = tp_q[t];
            if (ld[t]) begin
                tq_d[t] = (t == 8) ? i_rx_pause_quanta : i_rx_pfc_quanta;
                tp_d[t] = P_RELOAD;
            end else if (tq_q[t] != '0) begin
                if (tp_q[t] == '0) begin
                    tq_d[t] = tq_q[t] - 16'd1;
                    tp_d[t] = P_RELOAD;
                end else begin
                    tp_d[t] = tp_q[t] - PW'(1);
                end
            end
        end
    end

    // One count per cycle no matter how many timers the strobes hit.
    always_comb begin
        event_w = (i_rx_pause_valid && (i_rx_pause_quanta != '0)) ||
                  (i_rx_pfc_valid && (i_rx_pfc_quanta != '0) && (i_rx_pfc_class_en != '0));
        xoff_d  = (event_w && (xoff_q != '1)) ? xoff_q + 16'd1 : xoff_q;
    end

    always_ff @(posedge clk) begin
        if (softreset) begin
            for (int unsigned t = 0; t < NT; t++) begin
                tq_q[t] <= '0;
                tp_q[t] <= '0;
            end
            xoff_q <= '0;
        end else begin
            for (int unsigned t = 0; t < NT; t++) begin
                tq_q[t] <= tq_d[t];
                tp_q[t] <= tp_d[t];
            end
            xoff_q <= xoff_d;
        end
    end

    always_comb begin
        o_pause_active = (tq_q[8] != '0);
        for (int unsigned c = 0; c < 8; c++) begin
            o_pfc_active[c] = (tq_q[c] != '0);
        end
    end

    assign o_xoff_events = xoff_q;

    // Gating is only ever evaluated at a packet boundary; once a packet has
    // started it runs to its last beat regardless of newly arriving pauses.
    assign blocked  = (state_q == IDLE) &&
                      i_fc_enable && (o_pause_active || o_pfc_active[i_tx_class]);
    assign m.tvalid = s.tvalid & ~blocked;
    assign s.tready = m.tready & ~blocked;
    assign hs       = s.tvalid & s.tready;

    always_ff @(posedge clk) begin
        if (softreset) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:    if (hs && !s.tlast) state_q <= PKT;
                PKT:     if (hs && s.tlast)  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Payload passes straight through.
    logic [DW-1:0]   data_w;
    logic [DW/8-1:0] keep_w;
    logic [UW-1:0]   user_w;

    assign data_w  = s.tdata;
    assign keep_w  = s.tkeep;
    assign user_w  = s.tuser;
    assign m.tdata = data_w;
    assign m.tkeep = keep_w;
    assign m.tuser = user_w;
    assign m.tlast = s.tlast;

endmodule

// File: tb/tb_eth_tx_pause_responder.sv
// Directed bench for eth_tx_pause_responder with QUANTA_CYCLES = 8.
module tb_eth_tx_pause_responder;

    logic        clk = 1'b0;
    logic        softreset;
    logic        fc_en;
    logic        pv;
    logic [15:0] pq;
    logic        fv;
    logic [7:0]  fen;
    logic [15:0] fq;
    logic [2:0]  tx_class;
    logic        pause_act;
    logic [7:0]  pfc_act;
    logic [15:0] xoff;

    int n_total = 0;
    int n_bad   = 0;

    eth_tx_pause_responder_if #(.DW(64), .UW(1)) s_if ();
    eth_tx_pause_responder_if #(.DW(64), .UW(1)) m_if ();

    eth_tx_pause_responder #(.DW(64), .UW(1), .QUANTA_CYCLES(8)) dut (
        .clk               (clk),
        .softreset         (softreset),
        .i_fc_enable       (fc_en),
        .i_rx_pause_valid  (pv),
        .i_rx_pause_quanta (pq),
        .i_rx_pfc_valid    (fv),
        .i_rx_pfc_class_en (fen),
        .i_rx_pfc_quanta   (fq),
        .i_tx_class        (tx_class),
        .s                 (s_if),
        .m                 (m_if),
        .o_pause_active    (pause_act),
        .o_pfc_active      (pfc_act),
        .o_xoff_events     (xoff)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns the cycle index (1 = first call cycle) at which s_tready is
    // seen high with the current inputs, or -1 if none within max_cyc.
    task automatic wait_hs(input int max_cyc, output int idx);
        idx = -1;
        for (int i = 1; i <= max_cyc; i++) begin
            #1;
            if (s_if.tready) begin
                idx = i;
                tick();
                return;
            end
            tick();
        end
    endtask

    int cnt_a, cnt_b, idx;

    initial begin
        softreset = 1'b1; fc_en = 1'b1;
        pv = 1'b0; pq = '0; fv = 1'b0; fen = '0; fq = '0; tx_class = '0;
        s_if.tvalid = 1'b1; s_if.tlast = 1'b1; s_if.tdata = 64'h0;
        s_if.tkeep = 8'hFF; s_if.tuser = 1'b0; m_if.tready = 1'b1;
        tick(); tick();
        softreset = 1'b0;
        #1;
        chk("rst_pause", 64'(pause_act), 64'd0);
        chk("rst_pfc", 64'(pfc_act), 64'd0);
        chk("rst_xoff", 64'(xoff), 64'd0);
        chk("rst_mvalid", 64'(m_if.tvalid), 64'd1);
        chk("rst_sready", 64'(s_if.tready), 64'd1);
        m_if.tready = 1'b0;
        #1;
        chk("rst_sready_lo", 64'(s_if.tready), 64'd0);
        m_if.tready = 1'b1;
        s_if.tvalid = 1'b0;
        tick();

        // PAUSE quanta 3 -> 24 active cycles
        pv = 1'b1; pq = 16'd3;
        tick();
        pv = 1'b0;
        cnt_a = 0;
        for (int i = 1; i <= 30; i++) begin
            #1;
            if (pause_act) cnt_a++;
            if (i == 1)  chk("p3_first", 64'(pause_act), 64'd1);
            if (i == 25) chk("p3_after", 64'(pause_act), 64'd0);
            tick();
        end
        chk("p3_len", 64'(cnt_a), 64'd24);

        // SOP during the window is accepted at cycle 25
        pv = 1'b1; pq = 16'd3;
        tick();
        pv = 1'b0;
        s_if.tvalid = 1'b1; s_if.tlast = 1'b1;
        wait_hs(40, idx);
        s_if.tvalid = 1'b0;
        chk("p3_sop_cycle", 64'(idx), 64'd25);
        chk("xoff_2", 64'(xoff), 64'd2);

        // 4-beat packet, PAUSE 0xFFFF at beat 2
        s_if.tvalid = 1'b1; s_if.tlast = 1'b0; s_if.tdata = 64'h1111_0000_0000_0001;
        #1; chk("pkt_b1", 64'(s_if.tready), 64'd1);
        tick();
        s_if.tdata = 64'h2; pv = 1'b1; pq = 16'hFFFF;
        #1; chk("pkt_b2", 64'(s_if.tready), 64'd1);
        tick();
        pv = 1'b0;
        s_if.tdata = 64'hDEAD_BEEF_0000_0003; s_if.tkeep = 8'h0F; s_if.tuser = 1'b1;
        #1;
        chk("pkt_b3", 64'(s_if.tready), 64'd1);
        chk("pkt_b3_pause", 64'(pause_act), 64'd1);
        chk("pkt_b3_mvalid", 64'(m_if.tvalid), 64'd1);
        chk("pkt_data", m_if.tdata, 64'hDEAD_BEEF_0000_0003);
        chk("pkt_keep", 64'(m_if.tkeep), 64'h0F);
        chk("pkt_user", 64'(m_if.tuser), 64'd1);
        tick();
        s_if.tdata = 64'h4; s_if.tlast = 1'b1; s_if.tkeep = 8'hFF; s_if.tuser = 1'b0;
        #1;
        chk("pkt_b4", 64'(s_if.tready), 64'd1);
        chk("pkt_b4_last", 64'(m_if.tlast), 64'd1);
        tick();
        s_if.tdata = 64'h5;
        cnt_a = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (s_if.tready || m_if.tvalid) cnt_a++;
            tick();
        end
        chk("next_sop_held", 64'(cnt_a), 64'd0);
        pv = 1'b1; pq = 16'd0;
        #1; chk("xon_cycle_held", 64'(s_if.tready), 64'd0);
        tick();
        pv = 1'b0;
        #1;
        chk("xon_sop_ok", 64'(s_if.tready), 64'd1);
        chk("xon_pause_off", 64'(pause_act), 64'd0);
        tick();
        s_if.tvalid = 1'b0;
        chk("xoff_3", 64'(xoff), 64'd3);

        // PFC class 2, quanta 2; class-0 traffic flows
        fv = 1'b1; fen = 8'h04; fq = 16'd2;
        tick();
        fv = 1'b0;
        s_if.tvalid = 1'b1; s_if.tlast = 1'b1; tx_class = 3'd0;
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (s_if.tready) cnt_a++;
            if (pfc_act == 8'h04) cnt_b++;
            tick();
        end
        s_if.tvalid = 1'b0;
        chk("pfc_c0_flow", 64'(cnt_a), 64'd20);
        chk("pfc_len", 64'(cnt_b), 64'd16);
        fv = 1'b1;
        tick();
        fv = 1'b0;
        s_if.tvalid = 1'b1; tx_class = 3'd2;
        wait_hs(30, idx);
        s_if.tvalid = 1'b0; tx_class = 3'd0;
        chk("pfc_c2_cycle", 64'(idx), 64'd17);
        chk("xoff_5", 64'(xoff), 64'd5);

        // PAUSE 1 and PFC class 0 quanta 5 together
        pv = 1'b1; pq = 16'd1; fv = 1'b1; fen = 8'h01; fq = 16'd5;
        tick();
        pv = 1'b0; fv = 1'b0;
        cnt_a = 0; cnt_b = 0;
        for (int i = 1; i <= 45; i++) begin
            #1;
            if (pause_act) cnt_a++;
            if (pfc_act[0]) cnt_b++;
            if (i == 1) chk("both_pfc_first", 64'(pfc_act), 64'h01);
            tick();
        end
        chk("both_pause_len", 64'(cnt_a), 64'd8);
        chk("both_pfc_len", 64'(cnt_b), 64'd40);
        chk("xoff_6", 64'(xoff), 64'd6);

        // Flow control disabled
        fc_en = 1'b0;
        pv = 1'b1; pq = 16'd10;
        tick();
        pv = 1'b0;
        s_if.tvalid = 1'b1; s_if.tlast = 1'b1;
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 85; i++) begin
            #1;
            if (s_if.tready) cnt_a++;
            if (pause_act) cnt_b++;
            tick();
        end
        s_if.tvalid = 1'b0; fc_en = 1'b1;
        chk("dis_flow", 64'(cnt_a), 64'd85);
        chk("dis_pause_len", 64'(cnt_b), 64'd80);
        chk("xoff_7", 64'(xoff), 64'd7);

        // Reset mid-packet with timers running
        s_if.tvalid = 1'b1; s_if.tlast = 1'b0;
        #1; chk("rst_sop", 64'(s_if.tready), 64'd1);
        tick();
        pv = 1'b1; pq = 16'd50; fv = 1'b1; fen = 8'hFF; fq = 16'd50;
        tick();
        pv = 1'b0; fv = 1'b0;
        #1; chk("mid_pkt_pass", 64'(s_if.tready), 64'd1);
        softreset = 1'b1;
        tick();
        softreset = 1'b0; s_if.tvalid = 1'b0;
        chk("post_rst_pause", 64'(pause_act), 64'd0);
        chk("post_rst_pfc", 64'(pfc_act), 64'd0);
        chk("post_rst_xoff", 64'(xoff), 64'd0);
        pv = 1'b1; pq = 16'd4;
        tick();
        pv = 1'b0;
        s_if.tvalid = 1'b1; s_if.tlast = 1'b0;
        #1; chk("post_rst_idle", 64'(s_if.tready), 64'd0);
        pv = 1'b1; pq = 16'd0;
        tick();
        pv = 1'b0; s_if.tvalid = 1'b0;
        chk("xoff_1", 64'(xoff), 64'd1);

        // Saturation
        pv = 1'b1; pq = 16'd1;
        for (int i = 0; i < 65533; i++) tick();
        chk("sat_fffe", 64'(xoff), 64'hFFFE);
        tick();
        chk("sat_ffff_1", 64'(xoff), 64'hFFFF);
        tick(); tick();
        chk("sat_ffff_3", 64'(xoff), 64'hFFFF);
        pv = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
